// File: rtl/ccff_loader.sv
// Configuration-chain bitstream loader: takes words over valid/ready, shifts them
// LSB-first onto the chain head and accumulates the parity of bits leaving the tail.
module ccff_loader #(
  parameter int CHAIN_LENGTH = 2048,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] bs_data,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  tail_parity
);

  localparam int CW  = $clog2(CHAIN_LENGTH + 1);
  localparam int WBW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0]  CHAIN_BITS     = CW'(CHAIN_LENGTH);
  localparam logic [CW-1:0]  LEFT_ONE       = CW'(1);
  localparam logic [WBW-1:0] WORD_BITS_FULL = WBW'(WORD_WIDTH);
  localparam logic [WBW-1:0] WORD_ONE       = WBW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state_reg;
  logic [CW-1:0]         bits_left_reg;
  logic [WBW-1:0]        word_bits_reg;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic                  full_word;

  // The last word of a load may be partial; only the remaining chain bits are shifted.
  assign full_word = int'(bits_left_reg) >= WORD_WIDTH;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_reg     <= IDLE;
      bits_left_reg <= '0;
      word_bits_reg <= '0;
      shift_reg     <= '0;
      bs_ready      <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tail_parity   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            tail_parity   <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b1;
            bs_ready      <= 1'b1;
            bits_left_reg <= CHAIN_BITS;
            state_reg     <= LOAD;
          end
        end
        LOAD: begin
          if (bs_valid) begin
            // Bit 0 goes straight to the head flop; the register holds what follows.
            shift_reg     <= bs_data >> 1;
            ccff_head     <= bs_data[0];
            ccff_shift_en <= 1'b1;
            bs_ready      <= 1'b0;
            word_bits_reg <= full_word ? WORD_BITS_FULL : WBW'(bits_left_reg);
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          tail_parity   <= tail_parity ^ ccff_tail;
          word_bits_reg <= word_bits_reg - WORD_ONE;
          bits_left_reg <= bits_left_reg - LEFT_ONE;
          shift_reg     <= shift_reg >> 1;
          if (word_bits_reg == WORD_ONE) begin
            ccff_shift_en <= 1'b0;
            ccff_head     <= 1'b0;
            if (bits_left_reg == LEFT_ONE) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= DONE;
            end else begin
              bs_ready  <= 1'b1;
              state_reg <= LOAD;
            end
          end else begin
            ccff_head <= shift_reg[0];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: a 20-bit and a 16-bit chain share stimulus;
// expected head bits are queued at each handshake and popped on every shift cycle.
module tb_ccff_loader;

  logic       clk = 1'b0;
  logic       prog_reset, start, bs_valid, ccff_tail;
  logic [7:0] bs_data;

  logic a_ready, a_head, a_en, a_busy, a_done, a_par;
  logic b_ready, b_head, b_en, b_busy, b_done, b_par;
  logic o_ready, o_head, o_en, o_busy, o_done, o_par;
  bit   sel16;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  bit   exp_q[$];
  bit   exp_par;

  localparam logic [3:0] TAIL_PAT = 4'b1011;

  always #5 clk = ~clk;

  ccff_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8)) u_dut20 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(a_ready),
    .ccff_head(a_head), .ccff_shift_en(a_en), .ccff_tail(ccff_tail),
    .busy(a_busy), .done(a_done), .tail_parity(a_par));

  ccff_loader #(.CHAIN_LENGTH(16), .WORD_WIDTH(8)) u_dut16 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(b_ready),
    .ccff_head(b_head), .ccff_shift_en(b_en), .ccff_tail(ccff_tail),
    .busy(b_busy), .done(b_done), .tail_parity(b_par));

  always_comb begin
    o_ready = sel16 ? b_ready : a_ready;
    o_head  = sel16 ? b_head  : a_head;
    o_en    = sel16 ? b_en    : a_en;
    o_busy  = sel16 ? b_busy  : a_busy;
    o_done  = sel16 ? b_done  : a_done;
    o_par   = sel16 ? b_par   : a_par;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_en"},    o_en,    0);
    check_eq({tag, "_head"},  o_head,  0);
    check_eq({tag, "_ready"}, o_ready, 0);
    check_eq({tag, "_busy"},  o_busy,  0);
    check_eq({tag, "_done"},  o_done,  0);
    check_eq({tag, "_par"},   o_par,   0);
  endtask

  // Runs one load; returns the cycle done was first seen (-1 if none) plus counts.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int stall_word, input int stall_len,
                          input int reset_at_shift, input int start_at_shift,
                          output int done_cyc, output int shifts, output int hs);
    logic [7:0] words [3];
    int  exp_left, word_idx, stall_left, tail_idx, n;
    bit  stalling, seen_done;
    words[0] = w0; words[1] = w1; words[2] = w2;
    exp_left = sel16 ? 16 : 20;
    word_idx = 0; stall_left = stall_len; tail_idx = 0;
    stalling = 0; seen_done = 0;
    shifts = 0; hs = 0; done_cyc = -1;
    exp_par = 0;
    exp_q.delete();

    start = 1'b1; bs_valid = 1'b1; bs_data = w0; ccff_tail = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    check_eq("ready_after_start", o_ready, 1);
    check_eq("busy_after_start",  o_busy,  1);
    check_eq("done_cleared",      o_done,  0);
    check_eq("parity_cleared",    o_par,   0);
    check_eq("en_in_first_load",  o_en,    0);

    for (int k = 0; k < 300 && !seen_done; k++) begin
      if (o_done) begin
        seen_done = 1;
        done_cyc  = cyc;
      end else begin
        if (o_en) begin
          shifts++;
          if (exp_q.size() == 0) check_eq("head_extra_shift", 1, 0);
          else check_eq("head", o_head, exp_q.pop_front());
        end
        ccff_tail = o_en ? TAIL_PAT[3 - (tail_idx % 4)] : 1'b1;
        if (o_en) begin
          exp_par ^= ccff_tail;
          tail_idx++;
        end
        start      = (start_at_shift > 0 && o_en && shifts == start_at_shift);
        prog_reset = (reset_at_shift > 0 && o_en && shifts == reset_at_shift);
        if (prog_reset) begin
          step();
          prog_reset = 1'b0;
          check_idle_outputs("after_reset");
          exp_q.delete();
          return;
        end
        if (o_ready && word_idx == stall_word && stall_left == stall_len && stall_len > 0)
          stalling = 1;
        if (stalling && stall_left > 0) begin
          check_eq("stall_ready", o_ready, 1);
          check_eq("stall_en",    o_en,    0);
          bs_valid = 1'b0;
          stall_left--;
        end else begin
          bs_valid = 1'b1;
        end
        bs_data = words[word_idx < 3 ? word_idx : 0];
        if (o_ready && bs_valid) begin
          n = exp_left < 8 ? exp_left : 8;
          for (int i = 0; i < n; i++) exp_q.push_back(bs_data[i]);
          exp_left -= n;
          word_idx++;
          hs++;
        end
        step();
        start = 1'b0;
      end
    end
    if (!seen_done) check_eq("done_timeout", 0, 1);
    check_eq("queue_drained",   exp_q.size(), 0);
    check_eq("done_head_low",   o_head, 0);
    check_eq("done_en_low",     o_en,   0);
    check_eq("done_busy_low",   o_busy, 0);
    check_eq("done_ready_low",  o_ready, 0);
    check_eq("tail_parity",     o_par,  exp_par);
  endtask

  initial begin
    int dc, sh, hs;
    prog_reset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0; ccff_tail = 1'b0;
    sel16 = 0; cyc = 0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    prog_reset = 1'b0;
    check_eq("rst20_en", a_en, 0);     check_eq("rst20_head", a_head, 0);
    check_eq("rst20_ready", a_ready, 0); check_eq("rst20_busy", a_busy, 0);
    check_eq("rst20_done", a_done, 0); check_eq("rst20_par", a_par, 0);
    check_eq("rst16_en", b_en, 0);     check_eq("rst16_ready", b_ready, 0);
    check_eq("rst16_busy", b_busy, 0); check_eq("rst16_done", b_done, 0);
    step();
    check_eq("idle_no_load", a_busy, 0);

    // Plain 20-bit load; tail pattern 1011 gives 15 ones -> parity 1.
    run_load(8'hA5, 8'h3C, 8'hFF, -1, 0, 0, 0, dc, sh, hs);
    check_eq("basic_done_cycle", dc, 24);
    check_eq("basic_shifts", sh, 20);
    check_eq("basic_handshakes", hs, 3);
    check_eq("basic_parity_one", o_par, 1);
    $display("load basic: done at cycle %0d, %0d shifts, parity %0d", dc, sh, o_par);

    // Five-cycle stall before the second word.
    run_load(8'h5A, 8'hC3, 8'h0F, 1, 5, 0, 0, dc, sh, hs);
    check_eq("stall_done_cycle", dc, 29);
    check_eq("stall_shifts", sh, 20);
    $display("load stall: done at cycle %0d, %0d shifts", dc, sh);

    // Reset at the 10th shift cycle, then a full reload.
    run_load(8'hA5, 8'h3C, 8'hFF, -1, 0, 10, 0, dc, sh, hs);
    check_eq("reset_no_done", dc, -1);
    run_load(8'h96, 8'h71, 8'hE8, -1, 0, 0, 0, dc, sh, hs);
    check_eq("reload_done_cycle", dc, 24);
    check_eq("reload_shifts", sh, 20);
    $display("load after reset: done at cycle %0d, %0d shifts", dc, sh);

    // Start during SHIFT is ignored; the following load from DONE checks the restart.
    run_load(8'h33, 8'hCC, 8'h99, -1, 0, 0, 3, dc, sh, hs);
    check_eq("ignored_start_done_cycle", dc, 24);
    check_eq("ignored_start_shifts", sh, 20);
    run_load(8'h01, 8'h80, 8'hFE, -1, 0, 0, 0, dc, sh, hs);
    check_eq("restart_done_cycle", dc, 24);
    $display("load start-in-shift and restart: done at cycle %0d", dc);

    // Exact-multiple chain.
    prog_reset = 1'b1;
    step();
    prog_reset = 1'b0;
    sel16 = 1;
    run_load(8'hA5, 8'h3C, 8'hFF, -1, 0, 0, 0, dc, sh, hs);
    check_eq("c16_done_cycle", dc, 19);
    check_eq("c16_shifts", sh, 16);
    check_eq("c16_handshakes", hs, 2);
    $display("load chain16: done at cycle %0d, %0d shifts, %0d handshakes", dc, sh, hs);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
